// File: rtl/reg_file_sb.sv
// Parametrised register file with write-through bypass, a late write-back port
// and a per-register pending scoreboard for read-after-write hazard stalls.
module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wr,
  input  logic [WIDTH-1:0]  wd,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic [ADDR_W:0]   pend_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs_r [NREGS];
  logic [NREGS-1:0]  pending_r;
  logic [NREGS-1:0]  pending_nxt_s;
  logic [ADDR_W:0]   pend_count_r;
  logic              we_s;
  logic              wbe_s;
  logic              rse_s;
  logic [WIDTH-1:0]  rd1_s;
  logic [WIDTH-1:0]  rd2_s;
  logic              busy1_s;
  logic              busy2_s;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  // Effective enables: anything aimed at the hardwired zero register is dropped.
  always_comb begin
    we_s  = regwrite && !is_zero_reg(wr);
    wbe_s = wb_valid && !is_zero_reg(wb_addr);
    rse_s = reserve  && !is_zero_reg(reserve_addr);
  end

  // Pending next state: the reservation is applied after the clear so it wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (wbe_s) begin
      pending_nxt_s[wb_addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (rse_s) begin
      pending_nxt_s[reserve_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Register array; primary port beats the late port on an address collision.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs_r[i] <= '0;
      end else if (we_s && (wr == ADDR_W'(i))) begin
        regs_r[i] <= wd;
      end else if (wbe_s && (wb_addr == ADDR_W'(i))) begin
        regs_r[i] <= wb_data;
      end else begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

  // Scoreboard and its registered population count.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r    <= '0;
      pend_count_r <= '0;
    end else begin
      pending_r    <= pending_nxt_s;
      pend_count_r <= popcount(pending_nxt_s);
    end
  end

  // Read port 1 priority mux: zero rule, primary bypass, late bypass, storage.
  always_comb begin
    if (is_zero_reg(rr1)) begin
      rd1_s   = '0;
    end else if ((BYPASS != 0) && regwrite && (wr == rr1)) begin
      rd1_s   = wd;
    end else if ((BYPASS != 0) && wb_valid && (wb_addr == rr1)) begin
      rd1_s   = wb_data;
    end else begin
      rd1_s   = regs_r[rr1];
    end
    if (is_zero_reg(rr1)) begin
      busy1_s = 1'b0;
    end else if ((BYPASS != 0) && wb_valid && (wb_addr == rr1)) begin
      busy1_s = 1'b0;
    end else begin
      busy1_s = pending_r[rr1];
    end
  end

  // Read port 2 priority mux, identical to port 1.
  always_comb begin
    if (is_zero_reg(rr2)) begin
      rd2_s   = '0;
    end else if ((BYPASS != 0) && regwrite && (wr == rr2)) begin
      rd2_s   = wd;
    end else if ((BYPASS != 0) && wb_valid && (wb_addr == rr2)) begin
      rd2_s   = wb_data;
    end else begin
      rd2_s   = regs_r[rr2];
    end
    if (is_zero_reg(rr2)) begin
      busy2_s = 1'b0;
    end else if ((BYPASS != 0) && wb_valid && (wb_addr == rr2)) begin
      busy2_s = 1'b0;
    end else begin
      busy2_s = pending_r[rr2];
    end
  end

  assign rd1        = rd1_s;
  assign rd2        = rd2_s;
  assign busy1      = busy1_s;
  assign busy2      = busy2_s;
  assign pend_count = pend_count_r;

endmodule
